// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM arbiter.
// Contents: FSM state enum, requester port indices, default bus widths,
// the latched command payload, and the strobe-phase wait counter width.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;
  // WAIT_CYC is limited to 0..7, so a 3-bit down-counter is enough.
  localparam int unsigned WAIT_W      = 3;

  localparam logic P_DSP = 1'b0;
  localparam logic P_AUX = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  // The owner's request, captured at grant time.
  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic                   port;
  } cmd_t;

endpackage

// File: rtl/sram_arb_select.sv
// Winner selection for the SRAM arbiter, with an optional anti-starvation counter.
// Ports:
//   i_clk, i_rst - clock and async active-high reset (present only with SRAM_ARB_FAIR_EN)
//   i_arb_en     - the arbiter is in IDLE and may grant this cycle
//   i_req0/1     - requests from port 0 (DSP) and port 1 (AUX)
//   o_win_c      - a grant is issued this cycle
//   o_port_c     - index of the winning port
// Macro SRAM_ARB_FAIR_EN: when defined, port 1 is forced through after
// STARVE_MAX consecutive port-0 grants taken while port 1 was waiting.
module sram_arb_select
  import sram_arb_pkg::*;
`ifdef SRAM_ARB_FAIR_EN
#(
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
`ifdef SRAM_ARB_FAIR_EN
  input  logic i_clk,
  input  logic i_rst,
`endif
  input  logic i_arb_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_win_c,
  output logic o_port_c
);

  assign o_win_c = i_arb_en && (i_req0 || i_req1);

`ifdef SRAM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved_c;

  assign starved_c = (starve_q >= CNT_W'(STARVE_MAX));
  assign o_port_c  = (i_req1 && (!i_req0 || starved_c)) ? P_AUX : P_DSP;

  // Count port-0 wins taken over a waiting port 1; any port-1 win or idle port 1 clears.
  always_comb begin
    starve_d = starve_q;
    if (i_arb_en) begin
      if (!i_req1) begin
        starve_d = '0;
      end else if (o_win_c && (o_port_c == P_AUX)) begin
        starve_d = '0;
      end else if (o_win_c && !starved_c) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign o_port_c = i_req0 ? P_DSP : P_AUX;
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter owning the external asynchronous 16-bit SRAM.
// Port 0 (DSP) has fixed priority over port 1 (AUX); one access at a time.
// Ports:
//   i_clk, i_rst                    - clock, async active-high reset
//   i_req*/i_we*/i_addr*/i_wdata*   - request side per port (hold until gnt)
//   o_gnt*                          - one-cycle accept pulse
//   o_rvalid*/o_rdata*              - read data pulse / held read data
//   o_busy                          - an access is in progress
//   o_SRAM_*, io_SRAM_DQ            - SRAM pins; DQ is tri-stated here
// Macro SRAM_ARB_FAIR_EN enables the port-1 starvation guard (STARVE_MAX).
//
// Internal state runs one cycle ahead of the pins: the strobe registers are
// loaded from the current state, so the pins show ACCESS from T+1 and DONE
// behaviour (strobes high, write data held, rvalid) at T+2+WAIT_CYC.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned DATA_W   = SRAM_DATA_W,
  parameter int unsigned WAIT_CYC = 1
`ifdef SRAM_ARB_FAIR_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  cmd_t              cmd_q, cmd_d;

  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              we_n_q, we_n_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              busy_q, busy_d;

  logic              arb_en_c, win_c, sel_port_c;

  assign arb_en_c = (state_q == S_IDLE);

  sram_arb_select
`ifdef SRAM_ARB_FAIR_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
    u_select (
`ifdef SRAM_ARB_FAIR_EN
    .i_clk    (i_clk),
    .i_rst    (i_rst),
`endif
    .i_arb_en (arb_en_c),
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .o_win_c  (win_c),
    .o_port_c (sel_port_c)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next state: latch the winner's request, then count out the strobe phase
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (win_c) begin
          state_d    = S_ACCESS;
          wait_d     = WAIT_W'(WAIT_CYC);
          cmd_d.port = sel_port_c;
          if (sel_port_c == P_AUX) begin
            cmd_d.we    = i_we1;
            cmd_d.addr  = SRAM_ADDR_W'(i_addr1);
            cmd_d.wdata = SRAM_DATA_W'(i_wdata1);
          end else begin
            cmd_d.we    = i_we0;
            cmd_d.addr  = SRAM_ADDR_W'(i_addr0);
            cmd_d.wdata = SRAM_DATA_W'(i_wdata0);
          end
        end
      end
      S_ACCESS: begin
        if (wait_q == '0) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; read data is captured on the edge that closes the last strobe cycle
  always_comb begin
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ce_n_d    = 1'b1;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    dq_oe_d   = 1'b0;
    // Covers the pin-side DONE cycle, which trails the internal DONE state.
    busy_d    = (state_d != S_IDLE) || (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (win_c) begin
          gnt0_d = (sel_port_c == P_DSP);
          gnt1_d = (sel_port_c == P_AUX);
        end
      end
      S_ACCESS: begin
        ce_n_d  = 1'b0;
        we_n_d  = !cmd_q.we;
        oe_n_d  = cmd_q.we;
        dq_oe_d = cmd_q.we;
      end
      S_DONE: begin
        // Write data stays on DQ one more cycle for SRAM hold time.
        dq_oe_d = cmd_q.we;
        if (!cmd_q.we) begin
          if (cmd_q.port == P_DSP) begin
            rvalid0_d = 1'b1;
            rdata0_d  = io_SRAM_DQ;
          end else begin
            rvalid1_d = 1'b1;
            rdata1_d  = io_SRAM_DQ;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset releases the SRAM bus immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
    end
  end

  assign o_gnt0      = gnt0_q;
  assign o_gnt1      = gnt1_q;
  assign o_rvalid0   = rvalid0_q;
  assign o_rvalid1   = rvalid1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_busy      = busy_q;
  // Address comes straight from the command register, stable from the grant cycle on.
  assign o_SRAM_ADDR = ADDR_W'(cmd_q.addr);
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign io_SRAM_DQ  = dq_oe_q ? DATA_W'(cmd_q.wdata) : {DATA_W{1'bz}};

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Shares the single external 16-bit SRAM between two requesters: port 0 (AudDSP sample read/write, high priority) and port 1 (debug/readback or display, low priority). Owns all SRAM pins, including the DQ tri-state and the WE_N/OE_N/CE_N timing. Accepts one request at a time over a req/gnt handshake and returns read data with a single-cycle valid pulse. Sits between AudDSP/auxiliary requesters and the board SRAM in the top level.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
WAIT_CYC, 1, extra cycles the strobe is held beyond the minimum one (range 0-7)
STARVE_MAX, 4, consecutive port-0 grants tolerated while port 1 waits (used only with SRAM_ARB_FAIR_EN)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_req0  in  1  port 0 request; hold until o_gnt0
i_we0  in  1  port 0: 1=write, 0=read
i_addr0  in  ADDR_W  port 0 address
i_wdata0  in  DATA_W  port 0 write data
o_gnt0  out  1  port 0 accept pulse
o_rvalid0  out  1  port 0 read-data valid pulse
o_rdata0  out  DATA_W  port 0 read data
i_req1, i_we1, i_addr1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1  as port 0, for port 1
o_busy  out  1  high when state is not IDLE
o_SRAM_ADDR  out  ADDR_W  SRAM address
io_SRAM_DQ  inout  DATA_W  SRAM data
o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes

Behaviour:
- Single clock i_clk. Asynchronous, active-high reset i_rst. All outputs are registered.
- Reset values:
  - gnt*, rvalid* = 0; rdata* = 0.
  - o_SRAM_ADDR = 0; WE_N = OE_N = CE_N = 1; LB_N = UB_N = 0 (always).
  - DQ high-Z; state IDLE; starvation counter 0.
- FSM:
  - IDLE: if any req is high, arbitrate, pulse the winner's gnt this cycle, latch addr/we/wdata/port, go to ACCESS. Otherwise stay.
  - ACCESS: lasts WAIT_CYC+1 cycles (down-counter). CE_N=0. Write: WE_N=0 and DQ driven with latched data. Read: OE_N=0 and DQ high-Z; sample DQ on the last ACCESS cycle. Then go to DONE.
  - DONE: one cycle. CE_N=1, WE_N=1, OE_N=1. A write keeps DQ driven this cycle (hold time). A read pulses the owner's rvalid with the sampled rdata. Then go to IDLE.
- Timing with gnt at cycle T:
  - ACCESS spans T+1 .. T+1+WAIT_CYC; DONE at T+2+WAIT_CYC.
  - Next grant no earlier than T+3+WAIT_CYC; with WAIT_CYC=1 that is 4 cycles per access.
- Handshake:
  - Requester holds req/addr/we/wdata stable until gnt.
  - Dropping req before gnt is legal; no access occurs.
  - req still high the cycle after gnt is treated as a new request at the next IDLE.
  - rdata holds its value until the next read for that port completes.
- Arbitration: fixed priority, port 0 beats port 1 on a simultaneous request. Arbitration happens only in IDLE; requests arriving during ACCESS/DONE wait.
- Address and data pass through unmodified. Address 2^ADDR_W-1 is legal; there is no wrap logic.
- Reset mid-operation aborts immediately: strobes deassert and DQ goes high-Z asynchronously. No gnt or rvalid is issued for the aborted access.

Optional Feature:
SRAM_ARB_FAIR_EN
- Defined: a counter increments on each port-0 grant while i_req1 is high. When it reaches STARVE_MAX, the next IDLE arbitration grants port 1 even if i_req0 is high. The counter clears on any port-1 grant, and on any IDLE cycle with i_req1 low.
- Undefined: pure fixed priority; port 1 can starve indefinitely; the counter logic is absent.

Decomposition:
- Package sram_arb_pkg:
  - state enum {S_IDLE, S_ACCESS, S_DONE};
  - port index constants P_DSP=0, P_AUX=1;
  - default ADDR_W/DATA_W localparams;
  - a command struct {we, addr, wdata, port}.
- One sub-module is natural: sram_arb_select, the combinational winner selection plus the starvation counter (the counter exists only under SRAM_ARB_FAIR_EN).

Test Plan:
1. Port 0 write, addr 0x00010, data 0xBEEF, WAIT_CYC=1, gnt0 at T -> CE_N=0 and WE_N=0 at T+1..T+2; DQ=0xBEEF at T+1..T+3; WE_N=1 at T+3; DQ high-Z at T+4.
2. Port 1 read of addr 0x00010 against an SRAM model holding 0xBEEF -> OE_N=0 at T+1..T+2; o_rvalid1=1 only at T+3 with o_rdata1=0xBEEF; o_rvalid0 stays 0.
3. i_req0 and i_req1 rise in the same IDLE cycle -> gnt0 at T, gnt1 at T+4, never both in one cycle.
4. Port 0 requests continuously, port 1 requests from the start, STARVE_MAX=4 -> with SRAM_ARB_FAIR_EN, gnt1 on the 5th arbitration; without it, no gnt1 in 20 accesses.
5. i_rst asserted during the write ACCESS of addr 0xFFFFF -> same cycle: WE_N=1, CE_N=1, DQ high-Z, o_SRAM_ADDR=0. After release: o_busy=0 and no gnt/rvalid until a new req.
6. Port 0 drops req while port 1 holds an access in ACCESS -> no gnt0 and no SRAM cycle for port 0; o_busy returns to 0 after DONE.
